seq_detect_101_nov: RTL and testbench

//   Serial bit-stream pattern detector for the non-overlapping sequence "101".

---
 rtl/seq_detect_101_nov.sv | 46 ++++
 tb/tb_seq_detect_101_nov.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_101_nov.sv
// Non-overlapping "101" serial pattern detector with a Mealy match flag
// and the 2-bit FSM state exposed for observation.
module seq_detect_101_nov (
    input  logic       clk,
    input  logic       rst,
    input  logic       seq_in,
    output logic       detected,
    output logic [1:0] state_out
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GOT1  = 2'b01;
    localparam logic [1:0] GOT10 = 2'b10;

    logic [1:0] state;
    logic [1:0] next_state;

    // State register; synchronous reset takes priority over any transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a completed match returns to IDLE so the final '1'
    // is never reused, and the unused encoding 2'b11 recovers to IDLE.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = seq_in ? GOT1 : IDLE;
            GOT1:    next_state = seq_in ? GOT1 : GOT10;
            GOT10:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Mealy output: asserted while the completing '1' is on the input.
    always_comb begin
        detected = (state == GOT10) && seq_in;
    end

    assign state_out = state;

endmodule

// File: tb/tb_seq_detect_101_nov.sv
// Directed and random checks for the non-overlapping "101" detector.
module tb_seq_detect_101_nov;

    logic       clk;
    logic       rst;
    logic       seq_in;
    logic       detected;
    logic [1:0] state_out;

    int vectors;
    int miscompares;

    seq_detect_101_nov dut (
        .clk       (clk),
        .rst       (rst),
        .seq_in    (seq_in),
        .detected  (detected),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            rst    = 1'b1;
            seq_in = (i == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            vectors++;
            if (state_out !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got %b expected 00", i, state_out);
            end
            vectors++;
            if (detected !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_detected[%0d]: got %b expected 0", i, detected);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_match();
        logic       bits  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       dets  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0] sts   [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 6; i++) begin
            seq_in = bits[i];
            #1;
            vectors++;
            if (detected !== dets[i]) begin
                miscompares++;
                $display("FAIL basic_detected[%0d]: got %b expected %b", i, detected, dets[i]);
            end
            @(posedge clk); #1;
            vectors++;
            if (state_out !== sts[i]) begin
                miscompares++;
                $display("FAIL basic_state[%0d]: got %b expected %b", i, state_out, sts[i]);
            end
        end
    endtask

    task automatic test_non_overlap();
        logic       bits [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       dets [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0] sts  [7] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 7; i++) begin
            seq_in = bits[i];
            #1;
            vectors++;
            if (detected !== dets[i]) begin
                miscompares++;
                $display("FAIL nonoverlap_detected[%0d]: got %b expected %b", i, detected, dets[i]);
            end
            @(posedge clk); #1;
            vectors++;
            if (state_out !== sts[i]) begin
                miscompares++;
                $display("FAIL nonoverlap_state[%0d]: got %b expected %b", i, state_out, sts[i]);
            end
        end
    endtask

    task automatic test_leading_ones();
        logic       bits [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       dets [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0] sts  [9] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 9; i++) begin
            seq_in = bits[i];
            #1;
            vectors++;
            if (detected !== dets[i]) begin
                miscompares++;
                $display("FAIL leading_detected[%0d]: got %b expected %b", i, detected, dets[i]);
            end
            @(posedge clk); #1;
            vectors++;
            if (state_out !== sts[i]) begin
                miscompares++;
                $display("FAIL leading_state[%0d]: got %b expected %b", i, state_out, sts[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        // prefix "10" brings the FSM to GOT10
        seq_in = 1'b1;
        @(posedge clk); #1;
        seq_in = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (state_out !== 2'b10) begin
            miscompares++;
            $display("FAIL midreset_prefix_state: got %b expected 10", state_out);
        end
        // reset cycle with seq_in=1: Mealy flag still high until the edge
        rst    = 1'b1;
        seq_in = 1'b1;
        #1;
        vectors++;
        if (detected !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_comb_detected: got %b expected 1", detected);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (state_out !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_state_after_rst: got %b expected 00", state_out);
        end
        seq_in = 1'b1;
        #1;
        vectors++;
        if (detected !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_detected_after: got %b expected 0", detected);
        end
        @(posedge clk); #1;
        vectors++;
        if (state_out !== 2'b01) begin
            miscompares++;
            $display("FAIL midreset_state_final: got %b expected 01", state_out);
        end
    endtask

    // Reference: a match happens when the last three bits since the previous
    // match (or reset) read "101"; the state is implied by that history.
    task automatic test_random_soak();
        logic [2:0] hist;
        int         since;
        logic       exp_det;
        logic [1:0] exp_st;
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        hist  = '0;
        since = 0;
        for (int i = 0; i < 200; i++) begin
            seq_in = 1'($urandom_range(0, 1));
            #1;
            exp_det = (since >= 2) && (hist[1:0] == 2'b10) && seq_in;
            vectors++;
            if (detected !== exp_det) begin
                miscompares++;
                $display("FAIL soak_detected[%0d]: got %b expected %b", i, detected, exp_det);
            end
            if (exp_det) begin
                since = 0;
                hist  = '0;
            end else begin
                hist  = {hist[1:0], seq_in};
                since = (since < 3) ? since + 1 : 3;
            end
            if (since == 0)
                exp_st = 2'b00;
            else if (hist[0])
                exp_st = 2'b01;
            else if (since >= 2 && hist[1:0] == 2'b10)
                exp_st = 2'b10;
            else
                exp_st = 2'b00;
            @(posedge clk); #1;
            vectors++;
            if (state_out !== exp_st || state_out === 2'b11) begin
                miscompares++;
                $display("FAIL soak_state[%0d]: got %b expected %b", i, state_out, exp_st);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        seq_in      = 1'b0;
        test_reset();
        test_basic_match();
        test_non_overlap();
        test_leading_ones();
        test_mid_reset();
        test_random_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
